// File: rtl/rf_pkg.sv
// Shared types, default widths and reset-value helper for the
// multi-port register file.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  function automatic logic [RF_DATA_W-1:0] rf_reset_value(
    input int unsigned index,
    input bit          reset_idx
  );
    return reset_idx ? RF_DATA_W'(index) : '0;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: range check, r0 rule, write/busy
// bypass and the output flops.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = 32,
  parameter bit R0_ZERO  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy_next,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  localparam bit FULL = NUM_REGS >= (1 << ADDR_W);

  logic              in_range;
  logic              is_zero;
  logic              visible;
  logic              hit;
  logic [DATA_W-1:0] data_d;
  logic              busy_d;

  always_comb begin
    in_range = FULL || (32'(addr) < 32'(NUM_REGS));
    is_zero  = R0_ZERO && (addr == '0);
    visible  = in_range && !is_zero;
    hit      = wr_en && (wr_addr == addr);
    data_d   = '0;
    busy_d   = 1'b0;
    if (visible) begin
      data_d = hit ? wr_data : regs[addr];
      busy_d = busy_next[addr];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data <= '0;
      busy <= 1'b0;
    end else begin
      data <= data_d;
      busy <= busy_d;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with busy scoreboard.
// Optional debug read port built only when RF_DEBUG_PORT_EN is defined.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int NUM_REGS  = 32,
  parameter int NUM_RD    = RF_NUM_RD,
  parameter bit R0_ZERO   = 1'b1,
  parameter bit RESET_IDX = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic [ADDR_W-1:0]        debug_addr,
  output logic [DATA_W-1:0]        debug_data
);

  localparam bit FULL = NUM_REGS >= (1 << ADDR_W);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                wr_ok;
  logic                claim_ok;

  always_comb begin
    wr_ok = wr_en
         && (FULL || 32'(wr_addr) < 32'(NUM_REGS))
         && !(R0_ZERO && wr_addr == '0);
    claim_ok = claim_en
            && (FULL || 32'(claim_addr) < 32'(NUM_REGS))
            && !(R0_ZERO && claim_addr == '0);
  end

  // Clear before set: a same-cycle claim outranks the writeback.
  always_comb begin
    busy_next = busy;
    if (wr_ok)
      busy_next[wr_addr] = 1'b0;
    if (claim_ok)
      busy_next[claim_addr] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= DATA_W'(rf_reset_value(i, RESET_IDX));
      busy <= '0;
    end else begin
      if (wr_ok)
        regs[wr_addr] <= wr_data;
      busy <= busy_next;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS),
      .R0_ZERO  (R0_ZERO)
    ) u_port (
      .clock     (clock),
      .reset     (reset),
      .addr      (rd_addr[k*ADDR_W +: ADDR_W]),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .regs      (regs),
      .busy_next (busy_next),
      .data      (rd_data[k*DATA_W +: DATA_W]),
      .busy      (rd_busy[k])
    );
  end

`ifdef RF_DEBUG_PORT_EN
  rf_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .R0_ZERO  (R0_ZERO)
  ) u_debug (
    .clock     (clock),
    .reset     (reset),
    .addr      (debug_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .regs      (regs),
    .busy_next (busy_next),
    .data      (debug_data),
    .busy      ()
  );
`else
  assign debug_data = '0;
`endif

endmodule

// File: tb/tb_register_file_mp.sv
// Random and directed checks of register_file_mp against an
// architectural model of registers and busy bits.
module tb_register_file_mp;
  import rf_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int NP = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0]    rd_busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             claim_en;
  logic [AW-1:0]    claim_addr;
  logic [AW-1:0]    debug_addr;
  logic [DW-1:0]    debug_data;

  register_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(NP),
    .R0_ZERO(1'b1), .RESET_IDX(1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .debug_addr (debug_addr),
    .debug_data (debug_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Architectural state: what each register holds, which are pending.
  logic [DW-1:0] m_reg [NR];
  bit            m_busy [NR];
  logic [DW-1:0] exp_data [NP];
  bit            exp_busy [NP];
  logic [DW-1:0] exp_dbg;
  bit            check_en = 1'b0;

  function automatic void check(string name, logic [DW-1:0] act,
                                logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req,
               $time);
    end
  endfunction

  function automatic bit live(int a);
    return a != 0 && a < NR;
  endfunction

  function automatic logic [DW-1:0] rd_val(int a);
    return live(a) ? m_reg[a] : '0;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) begin
      m_reg[i]  = DW'(i);
      m_busy[i] = 1'b0;
    end
    for (int k = 0; k < NP; k++) begin
      exp_data[k] = '0;
      exp_busy[k] = 1'b0;
    end
    exp_dbg = '0;
  endfunction

  // Apply one clock edge of architectural effect, then predict outputs.
  function automatic void m_step();
    int a;
    if (wr_en && live(int'(wr_addr))) begin
      m_reg[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (claim_en && live(int'(claim_addr)))
      m_busy[claim_addr] = 1'b1;
    for (int k = 0; k < NP; k++) begin
      a = int'(rd_addr[k*AW +: AW]);
      exp_data[k] = rd_val(a);
      exp_busy[k] = live(a) ? m_busy[a] : 1'b0;
    end
`ifdef RF_DEBUG_PORT_EN
    exp_dbg = rd_val(int'(debug_addr));
`else
    exp_dbg = '0;
`endif
  endfunction

  always @(negedge clock) begin
    if (check_en) begin
      for (int k = 0; k < NP; k++) begin
        check($sformatf("rd_data%0d", k), rd_data[k*DW +: DW],
              exp_data[k]);
        check($sformatf("rd_busy%0d", k), DW'(rd_busy[k]),
              DW'(exp_busy[k]));
      end
      check("debug_data", debug_data, exp_dbg);
    end
  end

  task automatic cycle(bit we, int wa, logic [DW-1:0] wd, bit ce,
                       int ca, int a0, int a1, int da);
    wr_en      = we;
    wr_addr    = AW'(wa);
    wr_data    = wd;
    claim_en   = ce;
    claim_addr = AW'(ca);
    rd_addr    = {AW'(a1), AW'(a0)};
    debug_addr = AW'(da);
    @(posedge clock);
    m_step();
    #1;
  endtask

  task automatic lit(string name, int k, logic [DW-1:0] d, bit b);
    check({name, "_d"}, rd_data[k*DW +: DW], d);
    check({name, "_b"}, DW'(rd_busy[k]), DW'(b));
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    claim_en = 0; claim_addr = 0;
    rd_addr = '0; debug_addr = 0;
    m_reset();
    check_en = 1'b1;
    #12;
    check("rst_rd", rd_data[DW-1:0], '0);
    check("rst_dbg", debug_data, '0);
    @(posedge clock); #1;
    reset = 1'b0;

    cycle(0, 0, 0, 0, 0, 5, 31, 5);
    lit("reset_idx5", 0, 32'd5, 0);
    lit("reset_idx31", 1, 32'd31, 0);

    cycle(1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 7, 7, 7);
    lit("wr_rd7", 0, 32'hDEADBEEF, 0);
    cycle(1, 7, 32'h1234, 0, 0, 7, 7, 7);
    lit("bypass_p0", 0, 32'h1234, 0);
    lit("bypass_p1", 1, 32'h1234, 0);

    cycle(0, 0, 0, 1, 9, 9, 9, 0);
    lit("claim9", 0, 32'd9, 1);
    cycle(1, 9, 32'h55, 0, 0, 9, 9, 0);
    lit("clear9", 1, 32'h55, 0);
    cycle(1, 9, 32'h66, 1, 9, 9, 9, 0);
    lit("claim_wins", 0, 32'h66, 1);

    cycle(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    lit("r0_zero", 0, 32'h0, 0);

    cycle(1, 3, 32'hAA, 1, 4, 3, 4, 3);
    lit("r3_aa", 0, 32'hAA, 0);
    lit("r4_busy", 1, 32'd4, 1);

    // Reset pulse between edges must clear outputs immediately.
    #2 reset = 1'b1;
    m_reset();
    #1;
    lit("async_p0", 0, 32'h0, 0);
    lit("async_p1", 1, 32'h0, 0);
    #1 reset = 1'b0;
    cycle(0, 0, 0, 0, 0, 3, 4, 3);
    lit("post_rst3", 0, 32'd3, 0);
    lit("post_rst4", 1, 32'd4, 0);
`ifdef RF_DEBUG_PORT_EN
    check("debug3", debug_data, 32'd3);
`else
    check("debug_off", debug_data, 32'd0);
`endif

    // Random traffic; narrow address pool to force hazards/bypasses.
    for (int n = 0; n < 600; n++) begin
      int pool;
      pool = (n < 300) ? 8 : NR;
      cycle(1'($urandom_range(0, 1)),
            int'($urandom_range(0, pool - 1)),
            $urandom,
            1'($urandom_range(0, 1)),
            int'($urandom_range(0, pool - 1)),
            int'($urandom_range(0, pool - 1)),
            int'($urandom_range(0, pool - 1)),
            int'($urandom_range(0, pool - 1)));
      if (n == 450) begin
        #2 reset = 1'b1;
        m_reset();
        #2 reset = 1'b0;
      end
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
